// File: rtl/ram16_pkg.sv
// Shared definitions for the RAM16 frame drain: data width and drain FSM state encoding.
package ram16_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } drain_state_e;

endpackage

// File: rtl/ram16_drain_sum.sv
// Frame checksum accumulator: running 16-bit sum, cleared at frame start.
// Only instantiated when RAM16_DRAIN_CHECKSUM_EN is defined.
module ram16_drain_sum
    import ram16_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] sum_o
);

    logic [DATA_WIDTH-1:0] sum_q;
    logic [DATA_WIDTH-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (en_i) begin
            sum_d = sum_q + data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/ram16_drain.sv
// Drains a full RAM16 buffer onto a valid/ready stream, one word per ISSUE/CAPTURE/PRESENT pass.
// Define RAM16_DRAIN_CHECKSUM_EN to append a 16-bit sum word as the last word of each frame.
//
// state   | meaning
// IDLE    | waiting for full_i
// ISSUE   | ram_read_o high for one cycle at the current address
// CAPTURE | RAM data valid, registered into m_data_o
// PRESENT | m_valid_o held until the consumer accepts the word
module ram16_drain
    import ram16_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  full_i,
    output logic                  ram_read_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_do_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic                  overrun_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    drain_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  read_q, read_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  ovr_q, ovr_d;
    logic                  hs;

`ifdef RAM16_DRAIN_CHECKSUM_EN
    logic                  csum_q, csum_d;
    logic [DATA_WIDTH-1:0] sum;
    logic                  sum_clr;
    logic                  sum_en;

    assign sum_clr = (state_q == IDLE) && full_i;
    assign sum_en  = (state_q == CAPTURE);

    ram16_drain_sum u_sum (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (sum_clr),
        .en_i   (sum_en),
        .data_i (ram_do_i),
        .sum_o  (sum)
    );
`endif

    assign hs = valid_q && m_ready_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        read_d  = 1'b0;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        ovr_d   = ovr_q;
`ifdef RAM16_DRAIN_CHECKSUM_EN
        csum_d  = csum_q;
`endif

        case (state_q)
            IDLE: begin
                if (full_i) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                    read_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = PRESENT;
                data_d  = ram_do_i;
                valid_d = 1'b1;
`ifdef RAM16_DRAIN_CHECKSUM_EN
                last_d  = 1'b0;
`else
                last_d  = (cnt_q == LAST_ADDR);
`endif
            end
            PRESENT: begin
                if (hs) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
`ifdef RAM16_DRAIN_CHECKSUM_EN
                    if (csum_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        csum_d  = 1'b0;
                    end else if (cnt_q == LAST_ADDR) begin
                        // sum already includes the last data word, present it straight away
                        csum_d  = 1'b1;
                        data_d  = sum;
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        cnt_d   = cnt_q + ADDR_WIDTH'(1);
                        read_d  = 1'b1;
                    end
`else
                    if (cnt_q == LAST_ADDR) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ISSUE;
                        cnt_d   = cnt_q + ADDR_WIDTH'(1);
                        read_d  = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (full_i && busy_q) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            read_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef RAM16_DRAIN_CHECKSUM_EN
            csum_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            read_q  <= read_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
`ifdef RAM16_DRAIN_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign ram_read_o = read_q;
    assign ram_addr_o = cnt_q;
    assign m_data_o   = data_q;
    assign m_valid_o  = valid_q;
    assign m_last_o   = last_q;
    assign busy_o     = busy_q;
    assign overrun_o  = ovr_q;

endmodule

// File: tb/tb_ram16_drain.sv
// Bench for ram16_drain: RAM16 model, stream monitor and per-scenario tasks checked against a frame model.
module tb_ram16_drain;
    import ram16_pkg::*;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
`ifdef RAM16_DRAIN_CHECKSUM_EN
    localparam int FLEN = DEPTH + 1;
`else
    localparam int FLEN = DEPTH;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  full_i;
    logic                  ram_read_o;
    logic [AW-1:0]         ram_addr_o;
    logic [DATA_WIDTH-1:0] ram_do_i = '0;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic                  m_last_o;
    logic                  busy_o;
    logic                  overrun_o;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] got_d [$];
    logic                  got_l [$];
    int                    rd_addr [$];
    int                    reads;
    logic [DATA_WIDTH-1:0] exp_d [$];
    int                    checks = 0;
    int                    errors = 0;

    ram16_drain #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .full_i     (full_i),
        .ram_read_o (ram_read_o),
        .ram_addr_o (ram_addr_o),
        .ram_do_i   (ram_do_i),
        .m_data_o   (m_data_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .m_last_o   (m_last_o),
        .busy_o     (busy_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk = ~clk;

    // RAM16: registered read, data valid the cycle after the strobe
    always @(posedge clk) begin
        if (ram_read_o) ram_do_i <= mem[ram_addr_o];
    end

    always @(negedge clk) begin
        if (m_valid_o && m_ready_i) begin
            got_d.push_back(m_data_o);
            got_l.push_back(m_last_o);
        end
        if (ram_read_o) begin
            rd_addr.push_back(int'(ram_addr_o));
            reads = reads + 1;
        end
    end

    task automatic build_exp();
        logic [DATA_WIDTH-1:0] s;
        s = '0;
        exp_d.delete();
        for (int i = 0; i < DEPTH; i++) begin
            exp_d.push_back(mem[i]);
            s = s + mem[i];
        end
`ifdef RAM16_DRAIN_CHECKSUM_EN
        exp_d.push_back(s);
`endif
    endtask

    task automatic load_rand();
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_WIDTH'($urandom);
        build_exp();
    endtask

    task automatic clear_obs();
        got_d.delete();
        got_l.delete();
        rd_addr.delete();
        reads = 0;
    endtask

    task automatic pulse_full();
        @(posedge clk); #1 full_i = 1'b1;
        @(posedge clk); #1 full_i = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        full_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", m_valid_o); end
        checks++; if (ram_read_o !== 1'b0) begin errors++; $display("FAIL rst_read got %b want 0", ram_read_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", overrun_o); end
        checks++; if (m_last_o !== 1'b0) begin errors++; $display("FAIL rst_last got %b want 0", m_last_o); end
        checks++; if (m_data_o !== 16'h0000) begin errors++; $display("FAIL rst_data got %h want 0000", m_data_o); end
        checks++; if (ram_addr_o !== '0) begin errors++; $display("FAIL rst_addr got %0d want 0", ram_addr_o); end
        @(posedge clk); #1 rst = 1'b1; full_i = 1'b0;
        clear_obs();
        repeat (4) @(negedge clk);
        checks++; if (busy_o !== 1'b0 || reads != 0) begin
            errors++; $display("FAIL rst_full_ignored busy %b reads %0d want 0 0", busy_o, reads);
        end
    endtask

    task automatic test_basic();
        bit to;
        int lat;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'hB000 + DATA_WIDTH'(i);
        build_exp();
        clear_obs();
        m_ready_i = 1'b1;
        lat = 0;
        @(posedge clk); #1 full_i = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n == 1) full_i = 1'b0;
            @(negedge clk);
            if (m_valid_o) begin lat = n; break; end
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL basic_latency got %0d want 3", lat); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout busy stuck got 1 want 0"); end
        checks++; if (got_d.size() != FLEN) begin errors++; $display("FAIL basic_len got %0d want %0d", got_d.size(), FLEN); end
        for (int i = 0; i < FLEN && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == FLEN - 1)) begin
                errors++; $display("FAIL basic_word%0d got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], (i == FLEN - 1));
            end
        end
`ifdef RAM16_DRAIN_CHECKSUM_EN
        checks++; if (got_d.size() != 9 || got_d[8] !== 16'h801C) begin
            errors++; $display("FAIL basic_checksum got %h want 801c", (got_d.size() == 9) ? got_d[8] : 16'hxxxx);
        end
`else
        checks++; if (got_l.size() != 8 || got_l[7] !== 1'b1) begin errors++; $display("FAIL basic_last7 got missing want 1"); end
`endif
        checks++; if (reads != DEPTH) begin errors++; $display("FAIL basic_reads got %0d want %0d", reads, DEPTH); end
        checks++; if (busy_o !== 1'b0 || overrun_o !== 1'b0) begin
            errors++; $display("FAIL basic_end busy %b ovr %b want 0 0", busy_o, overrun_o);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int r0;
        bit found;
        load_rand();
        clear_obs();
        m_ready_i = 1'b1;
        pulse_full();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (got_d.size() == 3) begin found = 1'b1; m_ready_i = 1'b0; break; end
            @(posedge clk); #1;
        end
        checks++; if (!found) begin errors++; $display("FAIL bp_reach_word3 got timeout want word 3"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid_o) break;
        end
        r0 = reads;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (m_valid_o !== 1'b1 || m_data_o !== exp_d[3]) begin
                errors++; $display("FAIL bp_hold c%0d got %b/%h want 1/%h", c, m_valid_o, m_data_o, exp_d[3]);
            end
            @(negedge clk);
        end
        checks++; if (reads != r0) begin errors++; $display("FAIL bp_extra_read got %0d want %0d", reads, r0); end
        @(posedge clk); #1 m_ready_i = 1'b1;
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout busy stuck got 1 want 0"); end
        checks++; if (got_d.size() != FLEN || reads != DEPTH) begin
            errors++; $display("FAIL bp_len got %0d/%0d want %0d/%0d", got_d.size(), reads, FLEN, DEPTH);
        end
        for (int i = 0; i < FLEN && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, got_d[i], exp_d[i]); end
        end
    endtask

    task automatic test_random_ready();
        bit to;
        bit prev_stall;
        logic [DATA_WIDTH-1:0] prev_d;
        load_rand();
        clear_obs();
        m_ready_i = 1'b1;
        pulse_full();
        to = 1'b1;
        prev_stall = 1'b0;
        prev_d = '0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1 m_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (m_valid_o !== 1'b1 || m_data_o !== prev_d) begin
                    errors++; $display("FAIL rr_stable got %b/%h want 1/%h", m_valid_o, m_data_o, prev_d);
                end
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_d = m_data_o;
            if (!busy_o) begin to = 1'b0; break; end
        end
        m_ready_i = 1'b1;
        checks++; if (to) begin errors++; $display("FAIL rr_timeout busy stuck got 1 want 0"); end
        checks++; if (got_d.size() != FLEN) begin errors++; $display("FAIL rr_len got %0d want %0d", got_d.size(), FLEN); end
        for (int i = 0; i < FLEN && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == FLEN - 1)) begin
                errors++; $display("FAIL rr_word%0d got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], (i == FLEN - 1));
            end
        end
    endtask

    task automatic test_overrun();
        bit to;
        bit found;
        load_rand();
        clear_obs();
        m_ready_i = 1'b1;
        pulse_full();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (m_valid_o && got_d.size() == 2) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL ovr_reach_word2 got timeout want word 2"); end
        full_i = 1'b1;
        @(posedge clk); #1 full_i = 1'b0;
        @(negedge clk);
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun_o); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL ovr_timeout busy stuck got 1 want 0"); end
        repeat (6) @(negedge clk);
        checks++; if (busy_o !== 1'b0 || reads != DEPTH || got_d.size() != FLEN) begin
            errors++; $display("FAIL ovr_no_restart busy %b reads %0d words %0d want 0 %0d %0d", busy_o, reads, got_d.size(), DEPTH, FLEN);
        end
        for (int i = 0; i < FLEN && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL ovr_word%0d got %h want %h", i, got_d[i], exp_d[i]); end
        end
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun_o); end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit found;
        int r0;
        load_rand();
        clear_obs();
        m_ready_i = 1'b1;
        pulse_full();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (m_valid_o && got_d.size() == 4) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL rm_reach_word4 got timeout want word 4"); end
        rst = 1'b0;
        full_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (m_valid_o !== 1'b0 || busy_o !== 1'b0 || ram_read_o !== 1'b0 || overrun_o !== 1'b0) begin
            errors++; $display("FAIL rm_abort valid %b busy %b read %b ovr %b want 0 0 0 0", m_valid_o, busy_o, ram_read_o, overrun_o);
        end
        @(posedge clk); #1 rst = 1'b1; full_i = 1'b0;
        r0 = reads;
        repeat (4) @(negedge clk);
        checks++; if (reads != r0 || busy_o !== 1'b0 || m_valid_o !== 1'b0) begin
            errors++; $display("FAIL rm_quiet reads %0d busy %b valid %b want %0d 0 0", reads, busy_o, m_valid_o, r0);
        end
        load_rand();
        clear_obs();
        pulse_full();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL rm_timeout busy stuck got 1 want 0"); end
        checks++; if (got_d.size() != FLEN || rd_addr.size() != DEPTH) begin
            errors++; $display("FAIL rm_len got %0d/%0d want %0d/%0d", got_d.size(), rd_addr.size(), FLEN, DEPTH);
        end
        for (int i = 0; i < DEPTH && i < rd_addr.size() && i < got_d.size(); i++) begin
            checks++;
            if (rd_addr[i] != i || got_d[i] !== exp_d[i]) begin
                errors++; $display("FAIL rm_word%0d got addr %0d data %h want %0d %h", i, rd_addr[i], got_d[i], i, exp_d[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        load_rand();
        clear_obs();
        m_ready_i = 1'b1;
        pulse_full();
        wait_idle(to);
        checks++; if (to || got_d.size() != FLEN) begin
            errors++; $display("FAIL b2b_first got to %0b len %0d want 0 %0d", to, got_d.size(), FLEN);
        end
        load_rand();
        clear_obs();
        @(posedge clk); #1 full_i = 1'b1;
        @(posedge clk); #1 full_i = 1'b0;
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout busy stuck got 1 want 0"); end
        checks++; if (got_d.size() != FLEN || reads != DEPTH) begin
            errors++; $display("FAIL b2b_len got %0d/%0d want %0d/%0d", got_d.size(), reads, FLEN, DEPTH);
        end
        for (int i = 0; i < FLEN && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == FLEN - 1)) begin
                errors++; $display("FAIL b2b_word%0d got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], (i == FLEN - 1));
            end
        end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", overrun_o); end
    endtask

    initial begin
        rst = 1'b0;
        full_i = 1'b0;
        m_ready_i = 1'b1;
        reads = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_random_ready();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
